// File: rtl/x_delay_finder.sv
// ---------------------------------------------------------------------------
// x_delay_finder
// Measures the clock-cycle latency of a loopback path so firmware can program
// the shift-register delay line with a verified value. A 1-clock probe pulse
// is fired into the path and the clocks until its echo returns are counted.
// This repeats NTRIAL times. The block then reports the min/max latency, a
// stability flag, a timeout flag and a spurious-echo flag.
//
// Parameters
//   MXDLY   delay select width; max measurable latency = (1<<MXDLY)-1 clocks
//   NTRIAL  probe trials per measurement, 1..255
//
// Ports
//   clock     in   system clock, rising edge
//   reset_n   in   synchronous reset, active low
//   start     in   1-clock measurement request, ignored while busy
//   echo      in   returned probe from the path under test
//   probe     out  1-clock probe pulse into the path
//   busy      out  measurement in progress
//   done      out  1-clock pulse, result outputs valid from this cycle
//   dly_min   out  smallest latency over trials that returned
//   dly_max   out  largest latency over trials that returned
//   stable    out  all trials returned with identical latency
//   timeout   out  at least one trial saw no echo
//   spurious  out  an echo arrived while the path was being drained
// ---------------------------------------------------------------------------
module x_delay_finder #(
    parameter int MXDLY  = 4,
    parameter int NTRIAL = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             echo,
    output logic             probe,
    output logic             busy,
    output logic             done,
    output logic [MXDLY-1:0] dly_min,
    output logic [MXDLY-1:0] dly_max,
    output logic             stable,
    output logic             timeout,
    output logic             spurious
);

    localparam int MXSR = 1 << MXDLY;
    localparam logic [MXDLY-1:0] CNT_LAST = MXDLY'(MXSR - 1);
    localparam logic [7:0] TRIAL_LAST = 8'(NTRIAL);

    typedef enum logic [2:0] {IDLE, FIRE, LISTEN, GAP, DONE} state_t;

    state_t           state;
    logic [MXDLY-1:0] cnt;
    logic             gap_last;
    logic [7:0]       trial;
    logic [MXDLY-1:0] acc_min;
    logic [MXDLY-1:0] acc_max;
    logic             tmo;
    logic             spur;
    logic             ok;

    // The gap drains the path for MXSR+1 cycles: cnt sweeps 0..MXSR-1 and
    // gap_last adds the final cycle, so cnt can stay MXDLY bits wide.
    // Results are latched on the transition into DONE so they are already
    // visible in the cycle where done is high; an echo on that very last gap
    // cycle is folded into spurious directly.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            gap_last <= 1'b0;
            trial    <= '0;
            acc_min  <= '0;
            acc_max  <= '0;
            tmo      <= 1'b0;
            spur     <= 1'b0;
            ok       <= 1'b0;
            probe    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dly_min  <= '0;
            dly_max  <= '0;
            stable   <= 1'b0;
            timeout  <= 1'b0;
            spurious <= 1'b0;
        end else begin
            probe <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        trial   <= '0;
                        acc_min <= '1;
                        acc_max <= '0;
                        tmo     <= 1'b0;
                        spur    <= 1'b0;
                        ok      <= 1'b0;
                        cnt     <= '0;
                        probe   <= 1'b1;
                        state   <= FIRE;
                    end
                end
                FIRE: begin
                    if (echo) begin
                        // Latency 0: min becomes 0, max is unchanged.
                        acc_min  <= '0;
                        ok       <= 1'b1;
                        cnt      <= '0;
                        gap_last <= 1'b0;
                        state    <= GAP;
                    end else begin
                        cnt   <= MXDLY'(1);
                        state <= LISTEN;
                    end
                end
                LISTEN: begin
                    if (echo) begin
                        if (cnt < acc_min) acc_min <= cnt;
                        if (cnt > acc_max) acc_max <= cnt;
                        ok       <= 1'b1;
                        cnt      <= '0;
                        gap_last <= 1'b0;
                        state    <= GAP;
                    end else if (cnt == CNT_LAST) begin
                        tmo      <= 1'b1;
                        cnt      <= '0;
                        gap_last <= 1'b0;
                        state    <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (echo) spur <= 1'b1;
                    if (gap_last) begin
                        trial <= trial + 8'd1;
                        if (trial + 8'd1 == TRIAL_LAST) begin
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            dly_min  <= ok ? acc_min : '0;
                            dly_max  <= ok ? acc_max : '0;
                            stable   <= ok & ~tmo & (acc_min == acc_max);
                            timeout  <= tmo;
                            spurious <= spur | echo;
                            state    <= DONE;
                        end else begin
                            cnt   <= '0;
                            probe <= 1'b1;
                            state <= FIRE;
                        end
                    end else begin
                        if (cnt == CNT_LAST) gap_last <= 1'b1;
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
